// File: rtl/eep_i2c_slave.sv
// eep_i2c_slave: I2C serial-EEPROM emulator (X24C01 / 24C01 / 24C02) driving a byte-wide save-RAM port.
module eep_i2c_slave #(
  parameter int RD_LAT   = 2,
  parameter int PAGE_X01 = 4,
  parameter int PAGE_C0X = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bram_type,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] ram_do,
  output logic [7:0] ram_di,
  output logic [7:0] ram_addr,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       led
);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, CTRL, WADDR, WRITE, READ_FETCH, READ, ACK_OUT, ACK_IN} state_t;
  state_t state_q, state_d, next_q, next_d;
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, di_q, di_d;
  logic [LW-1:0] lat_q, lat_d;
  logic we_q, we_d, oe_q, oe_d, sda_o_q, sda_o_d, ack_ph_q, ack_ph_d;
  logic is_x01, is_on, start, stop, rise, fall, sda_cur;
  logic [7:0] byte_in, page_mask, addr_pg, addr_rd;
  // [0],[1] form the synchronizer, [2] is the history sample used for edge detection
  assign scl_d     = {scl_q[1:0], scl};
  assign sda_d     = {sda_q[1:0], sda_in};
  assign sda_cur   = sda_q[1];
  assign start     = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop      = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign rise      = scl_q[1] & ~scl_q[2];
  assign fall      = ~scl_q[1] & scl_q[2];
  assign is_x01    = bram_type == 4'd3;
  assign is_on     = bram_type == 4'd3 || bram_type == 4'd4 || bram_type == 4'd5;
  assign byte_in   = {shift_q[6:0], sda_cur};
  assign page_mask = is_x01 ? 8'(PAGE_X01 - 1) : 8'(PAGE_C0X - 1);
  assign addr_pg   = (addr_q & ~page_mask) | ((addr_q + 8'd1) & page_mask);
  assign addr_rd   = (bram_type == 4'd5) ? addr_q + 8'd1 : {1'b0, addr_q[6:0] + 7'd1};
  assign sda_out   = sda_o_q;
  assign ram_di    = di_q;
  assign ram_addr  = addr_q;
  assign ram_oe    = oe_q;
  assign ram_we    = we_q;
  assign led       = state_q != IDLE;
  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    addr_d   = we_q ? addr_pg : addr_q;
    di_d     = di_q;
    we_d     = 1'b0;
    oe_d     = oe_q;
    sda_o_d  = sda_o_q;
    ack_ph_d = ack_ph_q;
    lat_d    = lat_q;
    if (!is_on) begin
      state_d = IDLE;
      sda_o_d = 1'b1;
      oe_d    = 1'b0;
    end else if (start) begin
      state_d = CTRL;
      cnt_d   = 4'd0;
      sda_o_d = 1'b1;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      sda_o_d = 1'b1;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        CTRL, WADDR, WRITE: if (rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d    = 4'd0;
            ack_ph_d = 1'b0;
            state_d  = ACK_OUT;
            if (state_q == CTRL) begin
              if (is_x01)
                addr_d = {1'b0, byte_in[7:1]};
              if (!is_x01 && byte_in[7:4] != 4'hA)
                state_d = IDLE;
              else if (byte_in[0]) begin
                state_d = READ_FETCH;
                oe_d    = 1'b1;
                lat_d   = '0;
                next_d  = ACK_OUT;
              end else
                next_d = is_x01 ? WRITE : WADDR;
            end else if (state_q == WADDR) begin
              addr_d = (bram_type == 4'd4) ? {1'b0, byte_in[6:0]} : byte_in;
              next_d = WRITE;
            end else begin
              di_d   = byte_in;
              we_d   = 1'b1;
              next_d = WRITE;
            end
          end
        end
        READ_FETCH: if (lat_q == LW'(RD_LAT - 1)) begin
          shift_d  = ram_do;
          oe_d     = 1'b0;
          cnt_d    = 4'd0;
          ack_ph_d = 1'b0;
          state_d  = (next_q == ACK_OUT) ? ACK_OUT : READ;
          next_d   = READ;
        end else
          lat_d = lat_q + 1'b1;
        // the fall that ends our ACK also launches the MSB when a read follows
        ACK_OUT: if (fall) begin
          if (!ack_ph_q) begin
            sda_o_d  = 1'b0;
            ack_ph_d = 1'b1;
          end else begin
            state_d = next_q;
            sda_o_d = (next_q == READ) ? shift_q[7] : 1'b1;
            shift_d = (next_q == READ) ? {shift_q[6:0], 1'b0} : shift_q;
            cnt_d   = (next_q == READ) ? 4'd1 : 4'd0;
          end
        end
        READ: if (fall) begin
          if (cnt_q == 4'd8) begin
            sda_o_d = 1'b1;
            state_d = ACK_IN;
          end else begin
            sda_o_d = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        ACK_IN: if (rise) begin
          if (!sda_cur) begin
            addr_d  = addr_rd;
            state_d = READ_FETCH;
            oe_d    = 1'b1;
            lat_d   = '0;
            next_d  = READ;
          end else
            state_d = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      next_q   <= IDLE;
      scl_q    <= 3'b111;
      sda_q    <= 3'b111;
      cnt_q    <= 4'd0;
      shift_q  <= 8'd0;
      addr_q   <= 8'd0;
      di_q     <= 8'd0;
      lat_q    <= '0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      sda_o_q  <= 1'b1;
      ack_ph_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      next_q   <= next_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      di_q     <= di_d;
      lat_q    <= lat_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      sda_o_q  <= sda_o_d;
      ack_ph_q <= ack_ph_d;
    end
  end
endmodule

// File: tb/tb_eep_i2c_slave.sv
// tb_eep_i2c_slave: directed bench bit-banging I2C traffic into eep_i2c_slave with a registered RAM model.
module tb_eep_i2c_slave;
  localparam int Q = 5;
  logic clk = 0, rst = 1, scl = 1, sda_in = 1;
  logic [3:0] bram_type = 4'd0;
  logic sda_out, ram_oe, ram_we, led;
  logic [7:0] ram_do = 8'd0, ram_di, ram_addr;
  logic [7:0] mem [256];
  logic [7:0] we_addr_log[$], we_data_log[$], fetch_log[$];
  int oe_cycles = 0, low_cycles = 0, tests = 0, fails = 0;
  logic oe_prev = 0;
  eep_i2c_slave dut (.clk(clk), .rst(rst), .bram_type(bram_type), .scl(scl), .sda_in(sda_in),
    .sda_out(sda_out), .ram_do(ram_do), .ram_di(ram_di), .ram_addr(ram_addr), .ram_oe(ram_oe),
    .ram_we(ram_we), .led(led));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_oe) ram_do <= mem[ram_addr];
    if (ram_oe && !oe_prev) fetch_log.push_back(ram_addr);
    if (ram_we) begin
      we_addr_log.push_back(ram_addr);
      we_data_log.push_back(ram_di);
    end
    if (ram_oe) oe_cycles++;
    if (sda_out === 1'b0) low_cycles++;
    oe_prev = ram_oe;
  end
  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    sda_in = 1; wq(Q); scl = 1; wq(Q); sda_in = 0; wq(Q); scl = 0; wq(Q);
  endtask
  task automatic i2c_stop;
    sda_in = 0; wq(Q); scl = 1; wq(Q); sda_in = 1; wq(Q);
  endtask
  task automatic send_bit(input logic b);
    sda_in = b; wq(Q); scl = 1; wq(2 * Q); scl = 0; wq(Q);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_in = 1; wq(Q); scl = 1; wq(Q); ack = sda_out; wq(Q); scl = 0; wq(Q);
  endtask
  task automatic recv_byte(output logic [7:0] d, input logic mack);
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      wq(Q); scl = 1; wq(Q); d = {d[6:0], sda_out}; wq(Q); scl = 0; wq(Q);
    end
    sda_in = mack; wq(Q); scl = 1; wq(2 * Q); scl = 0; wq(Q); sda_in = 1;
  endtask
  task automatic test_reset;
    wq(3);
    tests++; if (sda_out !== 1'b1) begin fails++; $display("FAIL reset_sda got %b want 1", sda_out); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", ram_we); end
    tests++; if (ram_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b want 0", ram_oe); end
    tests++; if (ram_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want 00", ram_addr); end
    tests++; if (ram_di !== 8'h00) begin fails++; $display("FAIL reset_di got %h want 00", ram_di); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL reset_led got %b want 0", led); end
    rst = 0; wq(3);
  endtask
  task automatic test_x01_write;
    logic a0, a1;
    int w0 = we_addr_log.size();
    bram_type = 4'd3; wq(2);
    i2c_start;
    tests++; if (led !== 1'b1) begin fails++; $display("FAIL x01w_led_on got %b want 1", led); end
    send_byte(8'h0A, a0);
    send_byte(8'h3C, a1);
    tests++; if (a0 !== 1'b0) begin fails++; $display("FAIL x01w_ack_ctrl got %b want 0", a0); end
    tests++; if (a1 !== 1'b0) begin fails++; $display("FAIL x01w_ack_data got %b want 0", a1); end
    i2c_stop; wq(3);
    tests++; if (we_addr_log.size() - w0 !== 1) begin fails++; $display("FAIL x01w_we_count got %0d want 1", we_addr_log.size() - w0); end
    else begin
      tests++; if (we_addr_log[w0] !== 8'h05) begin fails++; $display("FAIL x01w_addr got %h want 05", we_addr_log[w0]); end
      tests++; if (we_data_log[w0] !== 8'h3C) begin fails++; $display("FAIL x01w_data got %h want 3c", we_data_log[w0]); end
    end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL x01w_led_off got %b want 0", led); end
  endtask
  task automatic test_random_read;
    logic a0, a1, a2;
    logic [7:0] d0, d1;
    int f0 = fetch_log.size();
    bram_type = 4'd5; mem[8'h42] = 8'h5A; mem[8'h43] = 8'hC3; wq(2);
    i2c_start; send_byte(8'hA0, a0); send_byte(8'h42, a1);
    i2c_start; send_byte(8'hA1, a2);
    recv_byte(d0, 1'b0); recv_byte(d1, 1'b1);
    i2c_stop; wq(3);
    tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL rr_acks got %b want 000", {a0, a1, a2}); end
    tests++; if (d0 !== 8'h5A) begin fails++; $display("FAIL rr_byte0 got %h want 5a", d0); end
    tests++; if (d1 !== 8'hC3) begin fails++; $display("FAIL rr_byte1 got %h want c3", d1); end
    tests++; if (ram_addr !== 8'h43) begin fails++; $display("FAIL rr_final_addr got %h want 43", ram_addr); end
    tests++; if (fetch_log.size() - f0 !== 2) begin fails++; $display("FAIL rr_fetch_count got %0d want 2", fetch_log.size() - f0); end
    else begin
      tests++; if (fetch_log[f0] !== 8'h42 || fetch_log[f0+1] !== 8'h43) begin fails++; $display("FAIL rr_fetch_addr got %h %h want 42 43", fetch_log[f0], fetch_log[f0+1]); end
    end
  endtask
  task automatic test_page_wrap;
    logic a;
    logic [7:0] d0, d1;
    logic [7:0] exp_a [4] = '{8'h0E, 8'h0F, 8'h08, 8'h09};
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int w0 = we_addr_log.size(), f0;
    bram_type = 4'd5; wq(2);
    i2c_start; send_byte(8'hA0, a); send_byte(8'h0E, a);
    for (int i = 0; i < 4; i++) send_byte(exp_d[i], a);
    i2c_stop; wq(3);
    tests++; if (we_addr_log.size() - w0 !== 4) begin fails++; $display("FAIL pw_we_count got %0d want 4", we_addr_log.size() - w0); end
    else for (int i = 0; i < 4; i++) begin
      tests++; if (we_addr_log[w0+i] !== exp_a[i] || we_data_log[w0+i] !== exp_d[i]) begin
        fails++; $display("FAIL pw_write%0d got %h:%h want %h:%h", i, we_addr_log[w0+i], we_data_log[w0+i], exp_a[i], exp_d[i]); end
    end
    bram_type = 4'd3; mem[8'h7F] = 8'h99; mem[8'h00] = 8'h77; wq(2);
    f0 = fetch_log.size();
    i2c_start; send_byte(8'hFF, a);
    recv_byte(d0, 1'b0); recv_byte(d1, 1'b1);
    i2c_stop; wq(3);
    tests++; if (d0 !== 8'h99 || d1 !== 8'h77) begin fails++; $display("FAIL x01r_data got %h %h want 99 77", d0, d1); end
    tests++; if (fetch_log.size() - f0 !== 2) begin fails++; $display("FAIL x01r_fetch_count got %0d want 2", fetch_log.size() - f0); end
    else begin
      tests++; if (fetch_log[f0] !== 8'h7F || fetch_log[f0+1] !== 8'h00) begin fails++; $display("FAIL x01r_wrap got %h %h want 7f 00", fetch_log[f0], fetch_log[f0+1]); end
    end
  endtask
  task automatic test_bad_device;
    logic a;
    int w0 = we_addr_log.size(), o0 = oe_cycles, l0 = low_cycles;
    bram_type = 4'd5; wq(2);
    i2c_start; send_byte(8'hB0, a);
    tests++; if (a !== 1'b1) begin fails++; $display("FAIL bad_ack got %b want 1", a); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL bad_idle_led got %b want 0", led); end
    i2c_stop; wq(3);
    tests++; if (low_cycles != l0) begin fails++; $display("FAIL bad_sda_low got %0d cycles want 0", low_cycles - l0); end
    tests++; if (we_addr_log.size() != w0 || oe_cycles != o0) begin fails++; $display("FAIL bad_strobes got we=%0d oe=%0d want 0 0", we_addr_log.size() - w0, oe_cycles - o0); end
  endtask
  task automatic test_interrupt;
    logic a;
    logic [7:0] d;
    int w0 = we_addr_log.size();
    bram_type = 4'd5; mem[8'h20] = 8'h00; wq(2);
    i2c_start; send_byte(8'hA0, a); send_byte(8'h10, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop; wq(3);
    tests++; if (we_addr_log.size() != w0) begin fails++; $display("FAIL stop_mid_write got %0d we want 0", we_addr_log.size() - w0); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL stop_led got %b want 0", led); end
    i2c_start; send_byte(8'hA0, a); send_byte(8'h20, a);
    i2c_start; send_byte(8'hA1, a);
    wq(Q); scl = 1; wq(Q);
    d[0] = sda_out;
    tests++; if (d[0] !== 1'b0) begin fails++; $display("FAIL rst_pre_sda got %b want 0", d[0]); end
    rst = 1; #1;
    tests++; if (sda_out !== 1'b1 || ram_oe !== 1'b0) begin fails++; $display("FAIL rst_read got sda=%b oe=%b want 1 0", sda_out, ram_oe); end
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL rst_led got %b want 0", led); end
    wq(3); rst = 0; sda_in = 1; wq(3);
  endtask
  task automatic test_off;
    logic a;
    int w0 = we_addr_log.size(), o0 = oe_cycles, l0 = low_cycles;
    bram_type = 4'd0; wq(2);
    i2c_start; send_byte(8'h0A, a); send_byte(8'h3C, a);
    tests++; if (led !== 1'b0) begin fails++; $display("FAIL off_led got %b want 0", led); end
    i2c_stop; wq(3);
    tests++; if (we_addr_log.size() != w0 || oe_cycles != o0) begin fails++; $display("FAIL off_strobes got we=%0d oe=%0d want 0 0", we_addr_log.size() - w0, oe_cycles - o0); end
    tests++; if (low_cycles != l0) begin fails++; $display("FAIL off_sda_low got %0d cycles want 0", low_cycles - l0); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset;
    test_x01_write;
    test_random_read;
    test_page_wrap;
    test_bad_device;
    test_interrupt;
    test_off;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eep_i2c_slave.md
Name: eep_i2c_slave

Overview:
- Synchronous I2C serial-EEPROM emulator sitting directly downstream of the Bandai FCG mapper's SCL/SDA register bits.
- Decodes START/STOP/bit traffic from the mapper-driven `scl` and `sda_in`, and returns `sda_out` for CPU read-back.
- Translates byte transfers into single-cycle accesses on the save-RAM port (`ram_addr`, `ram_di`, `ram_we`, `ram_oe`, `ram_do`).
- Supports X24C01 (address-in-control-byte), 24C01 and 24C02 protocols.

Parameters:
- RD_LAT, 2: clk cycles from `ram_oe` assertion to `ram_do` valid; the byte is latched after RD_LAT cycles.
- PAGE_X01, 4: write-page size in bytes for X24C01 (power of 2).
- PAGE_C0X, 8: write-page size in bytes for 24C01/24C02 (power of 2).

Ports:
- clk  in  1  system clock; all logic is on posedge clk.
- rst  in  1  asynchronous active-high reset.
- bram_type  in  4  3 = X24C01, 4 = 24C01, 5 = 24C02; any other value = off.
- scl  in  1  serial clock level from the mapper register (m2 domain); sampled on clk.
- sda_in  in  1  master data level from the mapper register; sampled on clk.
- sda_out  out  1  slave data; 1 = released, 0 = pull low.
- ram_do  in  8  save-RAM read data.
- ram_di  out  8  save-RAM write data.
- ram_addr  out  8  save-RAM byte address.
- ram_oe  out  1  read strobe, held for RD_LAT cycles.
- ram_we  out  1  one-cycle write strobe.
- led  out  1  high while a transfer is active.

Behaviour:
- Reset values: `sda_out`=1, `ram_we`=0, `ram_oe`=0, `ram_addr`=0, `ram_di`=0, `led`=0, state=IDLE.
- Sampling and edge detection:
  - 2-flop synchronizer on `scl` and `sda_in`, plus one history register.
  - START = `scl` high in both samples and `sda` 1→0. STOP = `scl` high in both samples and `sda` 0→1.
  - `scl` rise = sample a bit. `scl` fall = advance / drive `sda_out`. Both are detected in the same clk as the synchronized edge.
- START or STOP is recognised in every state and overrides the bit engine:
  - START → bit counter=0, state=CTRL; any pending read/write is abandoned.
  - STOP → state=IDLE, `sda_out`=1.
- States: IDLE, CTRL, WADDR, WRITE, READ_FETCH, READ, ACK_OUT, ACK_IN.
- CTRL (8 bits, MSB first):
  - X24C01: bits[7:1] = word address, bit0 = R/W. Load `ram_addr`={0,addr7}; ACK; then R→READ_FETCH, W→WRITE.
  - 24C0x: bits[7:4] must equal 4'b1010, else no ACK and go IDLE. R→READ_FETCH (current address); W→WADDR.
- WADDR (24C0x only): 8 bits load `ram_addr`; 24C01 masks bit7 to 0. ACK, then WRITE.
- WRITE:
  - After the 8th `scl` rise: `ram_di`=byte, `ram_we`=1 for exactly one clk.
  - Next clk: `ram_addr` low bits increment modulo the page size; upper bits are unchanged (page wrap). Then ACK.
- ACK_OUT:
  - On the `scl` fall following the 8th bit, `sda_out`=0.
  - On the next `scl` fall, `sda_out`=1 and enter the successor state.
- READ_FETCH: `ram_oe`=1 for RD_LAT clks, then latch `ram_do` into the shift register; `ram_oe`=0.
- READ:
  - Entry from CTRL: the MSB is placed on `sda_out` at the `scl` fall ending the ACK bit.
  - Subsequent bits shift out on each `scl` fall. After 8 bits, `sda_out`=1 and go to ACK_IN.
- ACK_IN (master ACK sampled on `scl` rise):
  - 0 → `ram_addr` increments with full wrap (X24C01/24C01: 7 bits, 127→0; 24C02: 255→0), then READ_FETCH.
  - 1 → IDLE, awaiting STOP/START.
- RD_LAT versus SCL period: RD_LAT+1 clks is always shorter than the SCL half-period (SCL comes from CPU register writes), so the fetch always completes before the first bit is needed. No stall logic.
- Off mode (`bram_type` not 3/4/5): state forced to IDLE; `sda_out`=1, `ram_we`=0, `ram_oe`=0.
- `led` = (state != IDLE).
- `rst` mid-transfer: immediate return to reset values; no partial `ram_we` is issued.

Test Plan:
- X24C01 write: START, ctrl 0x0A (addr 5, W), data 0x3C, STOP → one `ram_we` pulse with `ram_addr`=0x05, `ram_di`=0x3C; ACK low after both bytes; `led` 1 then 0.
- 24C02 random read: START, 0xA0, 0x42, reSTART, 0xA1, read 2 bytes with `ram_do` model mem[0x42]=0x5A, mem[0x43]=0xC3; master ACK then NACK → `sda_out` serialises 0x5A then 0xC3; `ram_addr` ends at 0x43.
- Page wrap: 24C02 write at 0x0E of 4 bytes → writes to 0x0E, 0x0F, 0x08, 0x09. X24C01 read at 0x7F with master ACK → next fetch at 0x00.
- Bad device: 24C02 ctrl 0xB0 → `sda_out` stays 1 during ACK; no `ram_we`/`ram_oe`; state IDLE.
- Interruptions: STOP after 4 data bits of a write → no `ram_we`. `rst` during READ → `sda_out`=1, `ram_oe`=0 in the same cycle.
- Off mode: `bram_type`=0 with full write sequence → no RAM strobes; `sda_out` constant 1.
